// File: rtl/iter_multiplier.sv
// Iterative radix-2^STEP multiplier with optional signed operands, long/short
// result width and accumulate. Early-terminates once the remaining multiplier is zero.
module iter_multiplier #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               is_signed,
    input  logic               long_mode,
    input  logic               accumulate,
    input  logic [WIDTH-1:0]   in0,
    input  logic [WIDTH-1:0]   in1,
    input  logic [2*WIDTH-1:0] acc,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               flag_n,
    output logic               flag_z
);

    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [PW-1:0]     prod_q, prod_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              long_q, long_d;
    logic              accum_q, accum_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [PW-1:0]     result_q, result_d;
    logic              flag_n_q, flag_n_d;
    logic              flag_z_q, flag_z_d;

    // Operand magnitudes for signed capture; |-2^(WIDTH-1)| wraps to itself as unsigned.
    logic             in0_neg_c, in1_neg_c;
    logic [WIDTH-1:0] mag0_c, mag1_c;
    logic [PW-1:0]    partial_c, signed_p_c, sum_c;

    always_comb begin
        in0_neg_c  = is_signed & in0[WIDTH-1];
        in1_neg_c  = is_signed & in1[WIDTH-1];
        mag0_c     = in0_neg_c ? WIDTH'(-in0) : in0;
        mag1_c     = in1_neg_c ? WIDTH'(-in1) : in1;
        partial_c  = PW'(mcand_q * PW'(mplier_q[STEP-1:0]));
        signed_p_c = neg_q ? PW'(-prod_q) : prod_q;
        sum_c      = PW'(signed_p_c + (accum_q ? acc_q : PW'(0)));
    end

    always_comb begin
        state_d  = state_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        long_d   = long_q;
        accum_d  = accum_q;
        done_d   = 1'b0;
        result_d = result_q;
        flag_n_d = flag_n_q;
        flag_z_d = flag_z_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mplier_d = mag0_c;
                    mcand_d  = PW'(mag1_c);
                    prod_d   = '0;
                    acc_d    = acc;
                    neg_d    = in0_neg_c ^ in1_neg_c;
                    long_d   = long_mode;
                    accum_d  = accumulate;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (mplier_q == '0) begin
                    state_d = FIN;
                end else begin
                    prod_d   = PW'(prod_q + partial_c);
                    mplier_d = mplier_q >> STEP;
                    mcand_d  = mcand_q << STEP;
                end
            end
            FIN: begin
                state_d = IDLE;
                if (!abort) begin
                    done_d = 1'b1;
                    if (long_q) begin
                        result_d = sum_c;
                        flag_n_d = sum_c[PW-1];
                        flag_z_d = (sum_c == '0);
                    end else begin
                        result_d = {{WIDTH{1'b0}}, sum_c[WIDTH-1:0]};
                        flag_n_d = sum_c[WIDTH-1];
                        flag_z_d = (sum_c[WIDTH-1:0] == '0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mplier_q <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            long_q   <= 1'b0;
            accum_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            long_q   <= long_d;
            accum_q  <= accum_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign flag_n = flag_n_q;
    assign flag_z = flag_z_q;

endmodule

// File: tb/tb_iter_multiplier.sv
// Directed-vector bench for iter_multiplier (WIDTH=32, STEP=2).
module tb_iter_multiplier;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned PW    = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            start, abort, is_signed, long_mode, accumulate;
    logic [WIDTH-1:0] in0, in1;
    logic [PW-1:0]   acc;
    logic            busy, done, flag_n, flag_z;
    logic [PW-1:0]   result;

    int n_chk = 0;
    int n_err = 0;

    iter_multiplier #(.WIDTH(WIDTH), .STEP(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .is_signed(is_signed), .long_mode(long_mode), .accumulate(accumulate),
        .in0(in0), .in1(in1), .acc(acc),
        .busy(busy), .done(done), .result(result),
        .flag_n(flag_n), .flag_z(flag_z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [PW-1:0] av, input logic sg,
                           input logic lg, input logic am);
        in0 = a; in1 = b; acc = av;
        is_signed = sg; long_mode = lg; accumulate = am;
    endtask

    // Drive start for one edge (edge 0); returns #1 after that edge.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [PW-1:0] av, input logic sg,
                         input logic lg, input logic am);
        @(negedge clk);
        set_ops(a, b, av, sg, lg, am);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges after edge 0 until done is seen; 40-cycle budget.
    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 cyc++;
            if (done) return;
        end
        chk({tag, "_timeout"}, 64'd0, 64'd1);
        cyc = -1;
    endtask

    task automatic run_op(input string tag,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [PW-1:0] av, input logic sg,
                          input logic lg, input logic am,
                          input logic [PW-1:0] exp_r, input int exp_lat,
                          input logic exp_n, input logic exp_z);
        int cyc;
        issue(a, b, av, sg, lg, am);
        // Scramble inputs after capture; they must not affect the operation.
        set_ops(~a, ~b, ~av, ~sg, ~lg, ~am);
        wait_done(tag, cyc);
        chk({tag, "_lat"}, PW'(cyc), PW'(exp_lat));
        chk({tag, "_res"}, result, exp_r);
        chk({tag, "_n"}, PW'(flag_n), PW'(exp_n));
        chk({tag, "_z"}, PW'(flag_z), PW'(exp_z));
    endtask

    task automatic count_done(input int ncyc, output int seen);
        seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1 if (done) seen++;
        end
    endtask

    initial begin
        int cyc, seen;
        logic [PW-1:0] held;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        set_ops('0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", PW'(busy), 64'd0);
        chk("rst_done", PW'(done), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_flags", PW'({flag_n, flag_z}), 64'd0);
        @(negedge clk) rst = 1'b0;

        run_op("ulong_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b0, 1'b1, 1'b0,
               64'hFFFF_FFFE_0000_0001, 18, 1'b1, 1'b0);
        run_op("zero_acc", 32'd0, 32'h1234_5678, 64'h123, 1'b0, 1'b1, 1'b1,
               64'h123, 2, 1'b0, 1'b0);
        run_op("zero_noacc", 32'd0, 32'h1234_5678, 64'h123, 1'b0, 1'b1, 1'b0,
               64'd0, 2, 1'b0, 1'b1);
        run_op("slong_acc", 32'hFFFF_FFFE, 32'd3, 64'h10, 1'b1, 1'b1, 1'b1,
               64'h0000_0000_0000_000A, 3, 1'b0, 1'b0);
        run_op("short_wrap", 32'h0001_0000, 32'h0001_0000, 64'd0, 1'b0, 1'b0, 1'b0,
               64'd0, 11, 1'b0, 1'b1);
        run_op("sshort_neg", 32'hFFFF_FFFF, 32'd5, 64'd0, 1'b1, 1'b0, 1'b0,
               64'h0000_0000_FFFF_FFFB, 3, 1'b1, 1'b0);
        run_op("smin_sq", 32'h8000_0000, 32'h8000_0000, 64'd0, 1'b1, 1'b1, 1'b0,
               64'h4000_0000_0000_0000, 18, 1'b0, 1'b0);
        run_op("short_accup", 32'd3, 32'd5, 64'hFFFF_FFFF_0000_0001, 1'b0, 1'b0, 1'b1,
               64'h10, 3, 1'b0, 1'b0);
        run_op("slong_negacc", 32'd7, 32'hFFFF_FFF6, 64'd0, 1'b1, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFBA, 4, 1'b1, 1'b0);

        // Start while busy is ignored; start during done begins the next op.
        issue(32'hFF, 32'd2, 64'd0, 1'b0, 1'b1, 1'b0);
        cyc = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            #1 cyc++;
            if (cyc == 2) begin
                set_ops(32'd9, 32'd9, 64'd0, 1'b0, 1'b1, 1'b0);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk("busy_ign_lat", PW'(cyc), 64'd6);
        chk("busy_ign_res", result, 64'h1FE);
        set_ops(32'd7, 32'd9, 64'd0, 1'b0, 1'b1, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b_busy", PW'(busy), 64'd1);
        wait_done("b2b", cyc);
        chk("b2b_lat", PW'(cyc), 64'd4);
        chk("b2b_res", result, 64'd63);

        // Abort at cycle 3 of the max-latency operation.
        held = result;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1 abort = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0; start = 1'b0;
        chk("abort_busy", PW'(busy), 64'd0);
        count_done(25, seen);
        chk("abort_nodone", PW'(seen), 64'd0);
        chk("abort_res", result, held);
        chk("abort_flags", PW'({flag_n, flag_z}), 64'd0);

        // Asynchronous reset mid-run.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b0, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mrst_busy", PW'(busy), 64'd0);
        chk("mrst_done", PW'(done), 64'd0);
        chk("mrst_result", result, 64'd0);
        chk("mrst_flags", PW'({flag_n, flag_z}), 64'd0);
        @(negedge clk) rst = 1'b0;
        count_done(25, seen);
        chk("mrst_nodone", PW'(seen), 64'd0);
        run_op("post_rst", 32'd7, 32'd9, 64'd0, 1'b0, 1'b1, 1'b0,
               64'd63, 4, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
